// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix execution path: opcodes, instruction field
// positions, matrix geometry and the execution FSM state type.
package matrix_pkg;

    localparam int unsigned MAT_WORDS = 13;
    localparam int unsigned MAT_DIM   = 5;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_READ  = 4'd2;
    localparam logic [3:0] OP_CLEAR = 4'd3;

    // Instruction layout: op[31:28] id[27:26] row[25:23] col[22:20] values[19:4]
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 28;
    localparam int unsigned ID_MSB  = 27;
    localparam int unsigned ID_LSB  = 26;
    localparam int unsigned ROW_MSB = 25;
    localparam int unsigned ROW_LSB = 23;
    localparam int unsigned COL_MSB = 22;
    localparam int unsigned COL_LSB = 20;
    localparam int unsigned VAL_MSB = 19;
    localparam int unsigned VAL_LSB = 4;

    // Index of the final word swept by a CLEAR
    localparam logic [3:0] CLR_LAST = 4'(MAT_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StRwait,
        StClr,
        StDone
    } state_e;

endpackage

// File: rtl/matrix_addr_gen.sv
// Combinational coordinate-to-word-address mapping, shared with the decode stage.
// Two matrix elements share one memory word, hence the halving of the element index.
module matrix_addr_gen
    import matrix_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic [1:0]        id,
    input  logic [2:0]        row,
    input  logic [2:0]        col,
    output logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] waddr,
    output logic              coord_err
);

    logic [ADDR_W-1:0] elem;

    // Full-width arithmetic; the largest legal address fits without wrap
    always_comb begin
        base      = ADDR_W'(id) * ADDR_W'(MAT_WORDS);
        elem      = ADDR_W'(row) * ADDR_W'(MAT_DIM) + ADDR_W'(col);
        waddr     = base + (elem >> 1);
        coord_err = (row >= 3'(MAT_DIM)) || (col >= 3'(MAT_DIM));
    end

endmodule

// File: rtl/matrix_exec_ctrl.sv
// Executes one matrix instruction at a time: single-word write, single-word read
// with one-cycle memory latency, or a full-matrix clear, then reports completion.
module matrix_exec_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err
);

    state_e            state_q, state_d;
    logic [3:0]        op_q;
    logic [1:0]        id_q;
    logic [2:0]        row_q, col_q;
    logic [DATA_W-1:0] val_q;
    logic [3:0]        clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [ADDR_W-1:0] base, waddr;
    logic              coord_err;
    logic              bad_instr;
    logic              unused_instr;

    assign unused_instr = ^instr[VAL_LSB-1:0];

    matrix_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .id        (id_q),
        .row       (row_q),
        .col       (col_q),
        .base      (base),
        .waddr     (waddr),
        .coord_err (coord_err)
    );

    // Illegal opcode, or a bad coordinate on an access that uses one
    assign bad_instr = (op_q > OP_CLEAR) ||
                       (((op_q == OP_WRITE) || (op_q == OP_READ)) && coord_err);

    assign rd_data = rd_data_q;

    // State, latched instruction fields, clear counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OP_NOP;
            id_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            val_q     <= '0;
            clr_cnt_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if (state_q == StIdle && instr_valid) begin
                op_q  <= instr[OP_MSB:OP_LSB];
                id_q  <= instr[ID_MSB:ID_LSB];
                row_q <= instr[ROW_MSB:ROW_LSB];
                col_q <= instr[COL_MSB:COL_LSB];
                val_q <= instr[VAL_MSB:VAL_LSB];
            end
            // Memory returns data the cycle after the read strobe, i.e. in RWAIT
            if (state_q == StRwait) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    // Next-state and Moore outputs; strobes only ever come from EXEC or CLR
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        instr_ready = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        done        = 1'b0;
        rd_valid    = 1'b0;
        err         = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                clr_cnt_d = '0;
                state_d   = StDone;
                if (!bad_instr) begin
                    if (op_q == OP_WRITE) begin
                        mem_we    = 1'b1;
                        mem_addr  = waddr;
                        mem_wdata = val_q;
                    end else if (op_q == OP_READ) begin
                        mem_re   = 1'b1;
                        mem_addr = waddr;
                        state_d  = StRwait;
                    end else if (op_q == OP_CLEAR) begin
                        state_d = StClr;
                    end
                end
            end
            StRwait: begin
                state_d = StDone;
            end
            StClr: begin
                mem_we   = 1'b1;
                mem_addr = base + ADDR_W'(clr_cnt_q);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = StDone;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            StDone: begin
                done     = 1'b1;
                err      = bad_instr;
                rd_valid = (op_q == OP_READ) && !bad_instr;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_exec_ctrl.sv
// Self-checking bench: directed cases plus randomized instructions compared against
// a word-memory reference model built from the instruction semantics.
module tb_matrix_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata = 16'h0;
    logic        done;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] mem     [64];
    logic [15:0] ref_mem [64];
    logic [15:0] exp_rd;

    // Monitor state
    int          acc_cnt, acc_cyc, done_cnt, done_cyc, both_cnt, rcnt;
    logic [5:0]  raddr;
    logic        obs_err, obs_rdv;
    logic [15:0] obs_rdd;
    logic [5:0]  wa_q [$];
    logic [15:0] wd_q [$];

    matrix_exec_ctrl #(
        .ADDR_W (6),
        .DATA_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .done        (done),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with registered read: data valid the cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Observe the DUT mid-cycle
    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
        if (mem_we && mem_re) both_cnt++;
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (mem_re) begin
            rcnt++;
            raddr = mem_addr;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            obs_err  = err;
            obs_rdv  = rd_valid;
            obs_rdd  = rd_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        acc_cnt  = 0;
        done_cnt = 0;
        rcnt     = 0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issue one instruction, wait for completion, compare against the model
    task automatic run(input string tag, input logic [3:0] op, input logic [1:0] id,
                       input logic [2:0] row, input logic [2:0] col,
                       input logic [15:0] val, input bit hold);
        int n;
        int base, addr, lat, nw;
        bit bad;
        logic [5:0]  ea [$];
        logic [15:0] ed [$];
        clear_mon();
        wait_ready();
        instr       = {op, id, row, col, val, 4'($urandom)};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
        instr = $urandom;
        n = 0;
        while (done_cnt == 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        instr_valid = 1'b0;
        @(posedge clk); #1;

        base = int'(id) * 13;
        addr = base + (5 * int'(row) + int'(col)) / 2;
        bad  = (op > 4'd3) || ((op == 4'd1 || op == 4'd2) && (row > 3'd4 || col > 3'd4));
        lat  = bad ? 2 : (op == 4'd2) ? 3 : (op == 4'd3) ? 15 : 2;
        if (!bad && op == 4'd1) begin
            ea.push_back(6'(addr));
            ed.push_back(val);
        end
        if (!bad && op == 4'd3) begin
            for (int k = 0; k < 13; k++) begin
                ea.push_back(6'(base + k));
                ed.push_back(16'h0);
            end
        end

        chk({tag, " accepts"}, acc_cnt, 1);
        chk({tag, " dones"}, done_cnt, 1);
        chk({tag, " latency"}, done_cyc - acc_cyc, lat);
        chk({tag, " err"}, {31'b0, obs_err}, {31'b0, bad});
        chk({tag, " rd_valid"}, {31'b0, obs_rdv}, {31'b0, (!bad && op == 4'd2)});
        chk({tag, " reads"}, rcnt, (!bad && op == 4'd2) ? 1 : 0);
        if (!bad && op == 4'd2) begin
            chk({tag, " raddr"}, {26'b0, raddr}, addr);
            exp_rd = ref_mem[addr];
        end
        chk({tag, " rd_data"}, {16'b0, obs_rdd}, {16'b0, exp_rd});
        nw = ea.size();
        chk({tag, " writes"}, wa_q.size(), nw);
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            chk({tag, " waddr"}, {26'b0, wa_q[i]}, {26'b0, ea[i]});
            chk({tag, " wdata"}, {16'b0, wd_q[i]}, {16'b0, ed[i]});
            ref_mem[ea[i]] = ed[i];
        end
    endtask

    initial begin
        int n;
        logic [3:0] rop;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        exp_rd      = 16'h0;
        both_cnt    = 0;
        clear_mon();
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'($urandom);
            mem[i]    <= ref_mem[i];
        end
        ref_mem[51] = 16'h1234;
        mem[51]    <= 16'h1234;

        // Reset behaviour
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst ready", {31'b0, instr_ready}, 1);
        chk("rst strobes", {30'b0, mem_we, mem_re}, 0);
        chk("rst pulses", {29'b0, done, rd_valid, err}, 0);
        chk("rst addr", {26'b0, mem_addr}, 0);
        chk("rst wdata", {16'b0, mem_wdata}, 0);
        chk("rst rd_data", {16'b0, rd_data}, 0);

        // Directed cases
        run("write", 4'd1, 2'd1, 3'd2, 3'd3, 16'hBEEF, 1'b0);
        run("read", 4'd2, 2'd3, 3'd4, 3'd4, 16'h0, 1'b0);
        run("clear", 4'd3, 2'd2, 3'd7, 3'd7, 16'h5555, 1'b1);
        run("badrow", 4'd1, 2'd0, 3'd5, 3'd0, 16'h1111, 1'b0);
        run("badop", 4'hA, 2'd1, 3'd1, 3'd1, 16'h2222, 1'b0);
        run("nop", 4'd0, 2'd2, 3'd1, 3'd1, 16'h3333, 1'b0);
        run("rdback", 4'd2, 2'd1, 3'd2, 3'd3, 16'h0, 1'b0);

        // Reset in the middle of a CLEAR
        clear_mon();
        wait_ready();
        instr       = {4'd3, 2'd1, 26'h0};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n = 0;
        while (!(mem_we && mem_addr == 6'd18) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid-clr reached k5", {31'b0, (n < 30)}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-clr we off", {30'b0, mem_we, mem_re}, 0);
        @(posedge clk); #1;
        chk("mid-clr still off", {30'b0, mem_we, mem_re}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid-clr ready", {31'b0, instr_ready}, 1);
        chk("mid-clr no done", done_cnt, 0);
        chk("mid-clr words", wa_q.size(), 6);
        for (int k = 0; k < 6; k++) ref_mem[13 + k] = 16'h0;
        exp_rd = 16'h0;

        // Randomized instructions, biased toward legal coordinates
        for (int t = 0; t < 60; t++) begin
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                              : 4'($urandom_range(0, 3));
            run("rand", rop, 2'($urandom),
                3'(($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4)),
                3'(($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4)),
                16'($urandom), 1'($urandom));
        end

        chk("we/re overlap", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
